// File: rtl/seg_display_mux.sv
// Multiplexed common-anode seven-segment driver with per-digit dp/blanking,
// leading-zero suppression, PWM brightness, anode dead-time and frame-synchronous updates.
module seg_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_DEAD = SLOT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz;
  } disp_t;

  localparam disp_t DISP_RESET = '{digits: '0, dp: '0, blank: '1, lz: 1'b0};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic [SLOT_W-1:0]      r_slot_cnt;
  logic [IDX_W-1:0]       r_digit_idx;
  logic [BRIGHT_BITS-1:0] r_pwm_cnt;
  logic                   r_load_pending;
  disp_t                  r_stg;
  disp_t                  r_act;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic [NUM_DIGITS-1:0]  r_an;
  logic                   r_frame_tick;

  disp_t                  w_in;
  logic                   w_slot_wrap;
  logic                   w_frame_wrap;
  logic [NUM_DIGITS-1:0]  w_supp;
  logic                   w_run;
  logic [3:0]             w_cur_digit;
  logic                   w_cur_dp;
  logic                   w_cur_dark;
  logic                   w_pwm_on;
  logic                   w_lit;
  logic [NUM_DIGITS-1:0]  w_an_nxt;

  assign w_in         = '{digits: digits, dp: dp_in, blank: blank_in, lz: lz_en};
  assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_slot_wrap && (r_digit_idx == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
      r_pwm_cnt   <= '0;
    end else begin
      r_pwm_cnt  <= r_pwm_cnt + BRIGHT_BITS'(1);
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + SLOT_W'(1);
      if (w_slot_wrap) begin
        r_digit_idx <= w_frame_wrap ? '0 : r_digit_idx + IDX_W'(1);
      end
    end
  end

  // A load on the wrap cycle goes straight to the active set so it shows in the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg          <= DISP_RESET;
      r_act          <= DISP_RESET;
      r_load_pending <= 1'b0;
    end else if (w_frame_wrap) begin
      if (load) begin
        r_act <= w_in;
      end else if (r_load_pending) begin
        r_act <= r_stg;
      end
      r_load_pending <= 1'b0;
    end else if (load) begin
      r_stg          <= w_in;
      r_load_pending <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_supp = '0;
    w_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_run     = w_run && (r_act.digits[4*i +: 4] == 4'h0) && !r_act.blank[i];
      w_supp[i] = r_act.lz && w_run;
    end

    w_cur_digit = 4'h0;
    w_cur_dp    = 1'b0;
    w_cur_dark  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) begin
        w_cur_digit = r_act.digits[4*i +: 4];
        w_cur_dp    = r_act.dp[i];
        w_cur_dark  = r_act.blank[i] || w_supp[i];
      end
    end

    w_pwm_on = (r_pwm_cnt < brightness) || (&brightness);
    w_lit    = (r_slot_cnt >= SLOT_DEAD) && !w_cur_dark && w_pwm_on;

    w_an_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_lit && (r_digit_idx == IDX_W'(i))) begin
        w_an_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_cur_dark ? 7'h7F : hex_to_seg(w_cur_digit);
      r_dp         <= w_cur_dark ? 1'b1 : ~w_cur_dp;
      r_an         <= w_an_nxt;
      r_frame_tick <= w_frame_wrap;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: cycle-count reference model, directed
// scenarios for each display feature, then randomized loads and brightness changes.
module tb_seg_display_mux;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int DC    = 1;
  localparam int BB    = 2;
  localparam int FRAME = ND * RD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic [ND-1:0]   dp_in = '0;
  logic [ND-1:0]   blank_in = '0;
  logic            lz_en = 1'b0;
  logic            load = 1'b0;
  logic [BB-1:0]   brightness = 2'd3;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   an;
  logic            frame_tick;

  always #5 clk = ~clk;

  seg_display_mux #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC),
    .BRIGHT_BITS(BB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits    (digits),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .lz_en     (lz_en),
    .load      (load),
    .brightness(brightness),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dpv;
    logic [3:0]  bl;
    logic        lz;
  } disp_t;

  disp_t      m_act, m_stg;
  bit         m_pend;
  int         cyc;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [3:0] exp_an;
  logic       exp_ft;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic bit is_supp(input int k);
    if (!m_act.lz || k == 0) return 1'b0;
    for (int j = k; j < ND; j++) begin
      if (m_act.d[4*j +: 4] != 4'h0 || m_act.bl[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    cyc     = 0;
    m_act   = '{d: 16'h0, dpv: 4'h0, bl: 4'hF, lz: 1'b0};
    m_stg   = m_act;
    m_pend  = 1'b0;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    exp_an  = 4'hF;
    exp_ft  = 1'b0;
  endtask

  // One clock: predict registered outputs from the pre-edge position in the frame, then compare.
  task automatic step();
    int         slot = cyc % RD;
    int         idx  = (cyc / RD) % ND;
    int         pwm  = cyc % (1 << BB);
    bit         wrap = ((cyc % FRAME) == FRAME - 1);
    bit         dark = m_act.bl[idx] || is_supp(idx);
    bit         lit  = !dark && slot >= DC && (pwm < int'(brightness) || brightness == 2'd3);
    logic [3:0] onehot = 4'b0001 << idx;
    disp_t      in_now = '{d: digits, dpv: dp_in, bl: blank_in, lz: lz_en};
    logic [6:0] n_seg = dark ? 7'h7F : seg_of(m_act.d[4*idx +: 4]);
    logic       n_dp  = dark ? 1'b1 : ~m_act.dpv[idx];
    logic [3:0] n_an  = lit ? ~onehot : 4'hF;
    if (wrap) begin
      if (load) m_act = in_now;
      else if (m_pend) m_act = m_stg;
      m_pend = 1'b0;
    end else if (load) begin
      m_stg  = in_now;
      m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_seg = n_seg;
    exp_dp  = n_dp;
    exp_an  = n_an;
    exp_ft  = wrap;
    check("seg", seg, exp_seg);
    check("dp", dp, exp_dp);
    check("an", an, exp_an);
    check("frame_tick", frame_tick, exp_ft);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic l);
    digits   = d;
    dp_in    = p;
    blank_in = b;
    lz_en    = l;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic wait_ft();
    int waited = 0;
    do begin
      step();
      waited++;
    end while (!frame_tick && waited < 3 * FRAME);
    check("frame_tick_seen", frame_tick, 1);
  endtask

  task automatic to_wrap_cycle();
    while ((cyc % FRAME) != FRAME - 1) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_ft"}, frame_tick, 1'b0);
  endtask

  int c_a, c_b, ft_at;

  initial begin
    model_reset();
    #22;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Dark until the first commit.
    c_a = 0;
    for (int i = 0; i < 40; i++) begin step(); if (an != 4'hF) c_a++; end
    check("dark_before_load", c_a, 0);

    // Scenario 1: basic multiplex, duty and frame period.
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    wait_ft();
    c_a = 0; ft_at = -1;
    for (int i = 1; i <= FRAME; i++) begin
      step();
      if (an == 4'b1110) c_a++;
      if (frame_tick && ft_at < 0) ft_at = i;
      if (i == 2) check("first_digit_seg", seg, 7'h0E);
    end
    check("an0_low_cycles", c_a, RD - DC);
    check("frame_period", ft_at, FRAME);

    // Scenario 2: leading-zero suppression.
    do_load(16'h0005, 4'h0, 4'h0, 1'b1);
    wait_ft();
    c_a = 0; c_b = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (an != 4'b1110 && an != 4'hF) c_a++;
      if (an == 4'b1110 && seg != 7'h12) c_b++;
    end
    check("lz_only_an0", c_a, 0);
    check("lz_an0_seg5", c_b, 0);
    do_load(16'h0005, 4'h0, 4'h0, 1'b0);
    wait_ft();
    run(FRAME);

    // Scenario 3: no tearing; a wrap-cycle load lands in that frame.
    do_load(16'h1111, 4'h0, 4'h0, 1'b0);
    wait_ft();
    run(10);
    do_load(16'h2222, 4'h0, 4'h0, 1'b0);
    run(3);
    do_load(16'h3333, 4'h0, 4'h0, 1'b0);
    run(2);
    check("tear_rest_of_frame", seg, 7'h79);
    wait_ft();
    step();
    check("commit_next_frame", seg, 7'h30);
    to_wrap_cycle();
    do_load(16'h4444, 4'h0, 4'h0, 1'b0);
    check("wrap_load_tick", frame_tick, 1'b1);
    step();
    check("wrap_load_same_frame", seg, 7'h19);
    run(FRAME);

    // Scenario 4: brightness.
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    wait_ft();
    brightness = 2'd1;
    c_a = 0;
    for (int i = 0; i < FRAME; i++) begin step(); if (an != 4'hF) c_a++; end
    check("bright1_on_cycles", c_a, ND);
    brightness = 2'd0;
    c_a = 0;
    for (int i = 0; i < FRAME; i++) begin step(); if (an != 4'hF) c_a++; end
    check("bright0_dark", c_a, 0);
    brightness = 2'd3;

    // Scenario 5: decimal point and blanking.
    do_load(16'h12AF, 4'b0100, 4'b1000, 1'b0);
    wait_ft();
    c_a = 0; c_b = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (!dp) c_a++;
      if (an == 4'b0111) c_b++;
    end
    check("dp2_cycles", c_a, RD);
    check("blank3_never_on", c_b, 0);

    // Scenario 6: asynchronous reset mid-slot.
    run(13);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    c_a = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin step(); if (an != 4'hF) c_a++; end
    check("dark_after_reset", c_a, 0);

    // Randomized loads, brightness changes and wrap-aligned loads.
    for (int it = 0; it < 200; it++) begin
      int sel = $urandom_range(0, 5);
      brightness = 2'($urandom_range(0, 3));
      if (sel <= 1) begin
        do_load(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom),
                4'($urandom) & 4'($urandom), 1'($urandom));
      end else if (sel == 2) begin
        to_wrap_cycle();
        do_load(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom),
                4'($urandom) & 4'($urandom), 1'($urandom));
      end else begin
        run($urandom_range(1, 40));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
